// File: rtl/cdp_mul_share_arb.sv
// Shares one CDP multiplier between two lanes; RR issue arbitration, in-order tag-routed return.
// Latency: zero-cycle combinational issue and return paths; op_done is registered (one cycle after the pipe empties).
// Backpressure: req*_rdy follows mul_rdy for the winner; mul_unit_rdy follows the head lane's rsp_rdy. Optional CDP_MUL_SHARE_ARB_PERF_EN adds the full-stall counter.
module cdp_mul_share_arb #(
    parameter int TAG_DEPTH = 4,
    parameter int CNT_W     = 3
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rstn,
    input  logic             op_en,
    output logic             op_done,
    input  logic             req0_vld,
    output logic             req0_rdy,
    input  logic [17:0]      req0_a,
    input  logic [16:0]      req0_b,
    input  logic             req1_vld,
    output logic             req1_rdy,
    input  logic [17:0]      req1_a,
    input  logic [16:0]      req1_b,
    output logic             mul_vld,
    input  logic             mul_rdy,
    output logic [17:0]      mul_datin_pd,
    output logic [16:0]      mul_intp_pd,
    input  logic             mul_unit_vld,
    output logic             mul_unit_rdy,
    input  logic [49:0]      mul_unit_pd,
    output logic             rsp0_vld,
    input  logic             rsp0_rdy,
    output logic [49:0]      rsp0_pd,
    output logic             rsp1_vld,
    input  logic             rsp1_rdy,
    output logic [49:0]      rsp1_pd,
    output logic [CNT_W-1:0] outstanding,
    output logic             err_orphan,
    output logic [15:0]      perf_full_stall
);

    localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(TAG_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 done_nxt;
    logic                 prio;
    logic [TAG_DEPTH-1:0] tag_mem;
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr;
    logic [CNT_W-1:0]     count;
    logic [CNT_W-1:0]     count_nxt;
    logic                 issue_ok;
    logic                 any_req;
    logic                 winner;
    logic                 issue;
    logic                 nonempty;
    logic                 head;
    logic                 pop;

    // Issue side: the winner is resolved combinationally so a lone request issues the same cycle.
    assign issue_ok     = (state == ST_RUN) && (count < DEPTH);
    assign any_req      = req0_vld | req1_vld;
    assign winner       = (req0_vld & req1_vld) ? prio : req1_vld;
    assign mul_vld      = issue_ok & any_req;
    assign issue        = mul_vld & mul_rdy;
    assign req0_rdy     = issue & ~winner;
    assign req1_rdy     = issue & winner;
    assign mul_datin_pd = winner ? req1_a : req0_a;
    assign mul_intp_pd  = winner ? req1_b : req0_b;

    // Return side: the oldest tag steers the result; a stalled head lane blocks everything behind it.
    assign nonempty     = (count != '0);
    assign head         = tag_mem[rd_ptr];
    assign rsp0_vld     = mul_unit_vld & nonempty & ~head;
    assign rsp1_vld     = mul_unit_vld & nonempty & head;
    assign rsp0_pd      = mul_unit_pd;
    assign rsp1_pd      = mul_unit_pd;
    assign mul_unit_rdy = nonempty & (head ? rsp1_rdy : rsp0_rdy);
    assign pop          = mul_unit_vld & mul_unit_rdy;

    assign count_nxt    = count + CNT_W'(issue) - CNT_W'(pop);
    assign outstanding  = count;

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (op_en) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!op_en) begin
                    if (count_nxt == '0) begin
                        state_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (count_nxt == '0) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state      <= ST_IDLE;
            op_done    <= 1'b0;
            prio       <= 1'b0;
            tag_mem    <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            err_orphan <= 1'b0;
        end else begin
            state   <= state_nxt;
            op_done <= done_nxt;
            count   <= count_nxt;
            if (issue) begin
                prio            <= ~winner;
                tag_mem[wr_ptr] <= winner;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (mul_unit_vld && !nonempty) begin
                err_orphan <= 1'b1;
            end
        end
    end

`ifdef CDP_MUL_SHARE_ARB_PERF_EN
    logic [15:0] perf_cnt;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            perf_cnt <= '0;
        end else if ((state == ST_RUN) && any_req && (count == DEPTH) && (perf_cnt != 16'hFFFF)) begin
            perf_cnt <= perf_cnt + 16'd1;
        end
    end

    assign perf_full_stall = perf_cnt;
`else
    assign perf_full_stall = '0;
`endif

endmodule

// File: tb/tb_cdp_mul_share_arb.sv
// Directed bench for cdp_mul_share_arb with a latency-3 multiplier model and an in-order scoreboard.
module tb_cdp_mul_share_arb;

    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          rstn;
    logic          op_en;
    logic          op_done;
    logic          req0_vld, req0_rdy, req1_vld, req1_rdy;
    logic [17:0]   req0_a, req1_a;
    logic [16:0]   req0_b, req1_b;
    logic          mul_vld, mul_rdy;
    logic [17:0]   mul_datin_pd;
    logic [16:0]   mul_intp_pd;
    logic          mul_unit_vld, mul_unit_rdy;
    logic [49:0]   mul_unit_pd;
    logic          rsp0_vld, rsp0_rdy, rsp1_vld, rsp1_rdy;
    logic [49:0]   rsp0_pd, rsp1_pd;
    logic [CW-1:0] outstanding;
    logic          err_orphan;
    logic [15:0]   perf_full_stall;

    cdp_mul_share_arb #(.TAG_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .nvdla_core_clk(clk), .nvdla_core_rstn(rstn), .op_en(op_en), .op_done(op_done),
        .req0_vld(req0_vld), .req0_rdy(req0_rdy), .req0_a(req0_a), .req0_b(req0_b),
        .req1_vld(req1_vld), .req1_rdy(req1_rdy), .req1_a(req1_a), .req1_b(req1_b),
        .mul_vld(mul_vld), .mul_rdy(mul_rdy), .mul_datin_pd(mul_datin_pd), .mul_intp_pd(mul_intp_pd),
        .mul_unit_vld(mul_unit_vld), .mul_unit_rdy(mul_unit_rdy), .mul_unit_pd(mul_unit_pd),
        .rsp0_vld(rsp0_vld), .rsp0_rdy(rsp0_rdy), .rsp0_pd(rsp0_pd),
        .rsp1_vld(rsp1_vld), .rsp1_rdy(rsp1_rdy), .rsp1_pd(rsp1_pd),
        .outstanding(outstanding), .err_orphan(err_orphan), .perf_full_stall(perf_full_stall)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Multiplier model: result = {issue index, a, b}, valid 3 cycles after the issue cycle.
    typedef struct {
        int          t;
        logic [49:0] pd;
    } ment_t;
    ment_t       mq[$];
    int          cyc    = 0;
    int          qn     = 0;
    int          head_t = 0;
    logic [49:0] model_pd = '0;
    logic        model_vld;
    logic        hold = 1'b0;
    logic        inj_vld = 1'b0;
    logic [49:0] inj_pd = '0;
    logic [14:0] mcnt = '0;
    logic        s_iss = 1'b0;
    logic        s_pop = 1'b0;
    logic [49:0] s_pd = '0;
    int          s_t = 0;

    assign model_vld    = (qn != 0) && (cyc >= head_t) && !hold;
    assign mul_unit_vld = model_vld | inj_vld;
    assign mul_unit_pd  = inj_vld ? inj_pd : model_pd;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (s_pop) mq.delete(0);
        if (s_iss) begin
            mq.push_back('{s_t, s_pd});
            mcnt++;
        end
        s_iss = 1'b0;
        s_pop = 1'b0;
        qn = mq.size();
        if (qn != 0) begin
            head_t   = mq[0].t;
            model_pd = mq[0].pd;
        end
    end

    // Scoreboard: expected lane and payload pushed on each accepted request, popped on each response.
    typedef struct packed {
        logic        lane;
        logic [49:0] pd;
    } exp_t;
    exp_t        exp_q[$];
    exp_t        e;
    int          lane_log[$];
    int          iss_cnt = 0;
    int          peak = 0;

    always @(negedge clk) begin
        if (rstn) begin
            s_iss = mul_vld && mul_rdy;
            s_pd  = {mcnt, mul_datin_pd, mul_intp_pd};
            s_t   = cyc + 3;
            s_pop = mul_unit_vld && mul_unit_rdy && model_vld && !inj_vld;
            if (req0_vld && req0_rdy) begin
                e = {1'b0, iss_cnt[14:0], req0_a, req0_b};
                exp_q.push_back(e);
                lane_log.push_back(0);
                iss_cnt++;
            end
            if (req1_vld && req1_rdy) begin
                e = {1'b1, iss_cnt[14:0], req1_a, req1_b};
                exp_q.push_back(e);
                lane_log.push_back(1);
                iss_cnt++;
            end
            if (rsp0_vld && rsp0_rdy) begin
                if (exp_q.size() == 0) check("rsp0_unexpected", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("rsp0_lane", {63'd0, e.lane}, 0);
                    check("rsp0_pd", rsp0_pd, e.pd);
                end
            end
            if (rsp1_vld && rsp1_rdy) begin
                if (exp_q.size() == 0) check("rsp1_unexpected", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("rsp1_lane", {63'd0, e.lane}, 1);
                    check("rsp1_pd", rsp1_pd, e.pd);
                end
            end
            if (int'(outstanding) > peak) peak = int'(outstanding);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            req0_a = 18'($urandom);
            req0_b = 17'($urandom);
            req1_a = 18'($urandom);
            req1_b = 17'($urandom);
        end
    endtask

    task automatic drain_wait(input string name);
        int n = 0;
        while ((outstanding != '0 || exp_q.size() != 0) && n < 200) begin
            tick(1);
            n++;
        end
        check(name, {63'd0, n < 200}, 1);
    endtask

    initial begin
        int          base;
        int          lastpop;
        int          donecyc;
        int          pulses;
        int          mn;
        int          mx;
        logic        saw_issue;
        logic [15:0] p0;
        logic [15:0] pdiff;

        rstn = 1'b0; op_en = 1'b0; mul_rdy = 1'b0;
        req0_vld = 1'b0; req1_vld = 1'b0; rsp0_rdy = 1'b0; rsp1_rdy = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        check("rst_outstanding", outstanding, 0);
        check("rst_op_done", op_done, 0);
        check("rst_err_orphan", err_orphan, 0);
        check("rst_mul_vld", mul_vld, 0);
        check("rst_req_rdy", {req1_rdy, req0_rdy}, 0);
        check("rst_mul_unit_rdy", mul_unit_rdy, 0);
        check("rst_rsp_vld", {rsp1_vld, rsp0_vld}, 0);
        check("rst_perf", perf_full_stall, 0);
        tick(1);
        rstn = 1'b1;
        tick(1);

        // Both lanes valid continuously: alternate 0,1,0,1 and outstanding peaks at 3
        rsp0_rdy = 1'b1; rsp1_rdy = 1'b1; mul_rdy = 1'b1; op_en = 1'b1;
        req0_vld = 1'b1; req1_vld = 1'b1;
        peak = 0;
        tick(14);
        req0_vld = 1'b0; req1_vld = 1'b0;
        drain_wait("t1_drain");
        check("t1_issue_count_ge4", {63'd0, lane_log.size() >= 4}, 1);
        if (lane_log.size() >= 4) begin
            for (int i = 0; i < 4; i++) check("t1_issue_order", lane_log[i], i % 2);
        end
        check("t1_peak", peak, 3);

        // Results withheld: exactly DEPTH issues, then lane 0 stalls
        hold = 1'b1;
        base = iss_cnt;
        req0_vld = 1'b1;
        tick(8);
        check("t2_issues", iss_cnt - base, DEPTH);
        @(negedge clk);
        check("t2_outstanding_full", outstanding, DEPTH);
        check("t2_req0_rdy", req0_rdy, 0);
        check("t2_mul_vld", mul_vld, 0);
        p0 = perf_full_stall;
        repeat (5) @(negedge clk);
        pdiff = perf_full_stall - p0;
`ifdef CDP_MUL_SHARE_ARB_PERF_EN
        check("t2_perf_inc", pdiff, 5);
`else
        check("t2_perf_tied", perf_full_stall, 0);
`endif
        tick(1);
        req0_vld = 1'b0; hold = 1'b0;
        drain_wait("t2_drain");

        // Two outstanding, op_en dropped: drain, no issue, single op_done after last pop
        hold = 1'b1;
        base = iss_cnt;
        req0_vld = 1'b1;
        tick(2);
        req0_vld = 1'b0; op_en = 1'b0;
        @(negedge clk);
        check("t3_outstanding2", outstanding, 2);
        tick(1);
        req0_vld = 1'b1; op_en = 1'b1;
        saw_issue = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (mul_vld || req0_rdy || op_done) saw_issue = 1'b1;
        end
        check("t3_no_issue_in_drain", saw_issue, 0);
        check("t3_issue_count", iss_cnt - base, 2);
        tick(1);
        req0_vld = 1'b0; hold = 1'b0;
        lastpop = -1; donecyc = -100; pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (mul_unit_vld && mul_unit_rdy) lastpop = cyc;
            if (op_done) begin
                pulses++;
                donecyc = cyc;
            end
        end
        check("t3_op_done_pulses", pulses, 1);
        check("t3_op_done_timing", donecyc, lastpop + 1);
        check("t3_outstanding0", outstanding, 0);
        tick(2);

        // Steady push+pop at DEPTH-1 across pointer wrap, lane 1 only
        base = iss_cnt;
        req1_vld = 1'b1;
        tick(6);
        mn = 99; mx = -1;
        repeat (10) begin
            @(negedge clk);
            if (int'(outstanding) < mn) mn = int'(outstanding);
            if (int'(outstanding) > mx) mx = int'(outstanding);
        end
        tick(1);
        req1_vld = 1'b0;
        check("t4_occ_min", mn, DEPTH - 1);
        check("t4_occ_max", mx, DEPTH - 1);
        check("t4_wrap_ops", {63'd0, (iss_cnt - base) >= 2 * DEPTH}, 1);
        drain_wait("t4_drain");

        // Head tag 1 stalled on rsp1_rdy blocks a later lane-0 result
        hold = 1'b1; rsp1_rdy = 1'b0;
        req1_vld = 1'b1;
        tick(1);
        req1_vld = 1'b0; req0_vld = 1'b1;
        tick(1);
        req0_vld = 1'b0; hold = 1'b0;
        tick(2);
        @(negedge clk);
        check("t5_mul_unit_vld", mul_unit_vld, 1);
        check("t5_mul_unit_rdy", mul_unit_rdy, 0);
        check("t5_rsp0_vld", rsp0_vld, 0);
        check("t5_rsp1_vld", rsp1_vld, 1);
        repeat (3) @(negedge clk);
        check("t5_outstanding_held", outstanding, 2);
        tick(1);
        rsp1_rdy = 1'b1;
        drain_wait("t5_drain");

        // Result with empty tag FIFO: sticky orphan error, never accepted
        tick(1);
        inj_vld = 1'b1; inj_pd = 50'h2_AAAA_5555_1234;
        @(negedge clk);
        check("t6_mul_unit_rdy", mul_unit_rdy, 0);
        check("t6_orphan_not_yet", err_orphan, 0);
        check("t6_rsp_vld", {rsp1_vld, rsp0_vld}, 0);
        tick(1);
        inj_vld = 1'b0;
        @(negedge clk);
        check("t6_orphan_set", err_orphan, 1);
        repeat (3) @(negedge clk);
        check("t6_orphan_sticky", err_orphan, 1);
        check("t6_scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
